// File: rtl/shift_pkg.sv
// Shared types and sizing helpers for the pipelined barrel shifter.
package shift_pkg;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10,
        ROR = 2'b11
    } shift_op_e;

    function automatic int LOG2W(input int width);
        return $clog2(width);
    endfunction

    function automatic int NGROUP(input int width, input int reg_every);
        return (LOG2W(width) + reg_every - 1) / reg_every;
    endfunction

    // Control fields that ride along with every slot; data/shamt/tag widths
    // depend on the instance and are wrapped around this in the top.
    typedef struct packed {
        shift_op_e op;
        logic      fill;
    } shift_ctl_t;

endpackage

// File: rtl/shift_group.sv
// Combinational group of consecutive log stages; stage i shifts by 2^i when
// its shamt bit is set. Only the group's own shamt bits are passed in.
module shift_group
    import shift_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int FIRST = 0,
    parameter int COUNT = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic [COUNT-1:0] shamt,
    input  logic [1:0]       op,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                  input int amt,
                                                  input logic [1:0] mode,
                                                  input logic fill_bit);
        logic [WIDTH-1:0] fill_mask;
        fill_mask = fill_bit ? ~({WIDTH{1'b1}} >> amt) : '0;
        case (shift_op_e'(mode))
            SLL:     return d << amt;
            SRL:     return d >> amt;
            SRA:     return (d >> amt) | fill_mask;
            default: return (d >> amt) | (d << (WIDTH - amt));
        endcase
    endfunction

    always_comb begin
        result = data;
        for (int s = 0; s < COUNT; s++) begin
            if (shamt[s]) begin
                result = shift_by(result, 1 << (FIRST + s), op, fill);
            end
        end
    end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: log stages grouped REG_EVERY at a time, each group
// followed by a slot register with per-slot valid/ready and bubble collapse.
module pipe_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [1:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int N  = LOG2W(WIDTH);
    localparam int NG = NGROUP(WIDTH, REG_EVERY);

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("pipe_shifter: WIDTH must be a power of two >= 2");
    end
    if (REG_EVERY < 1 || REG_EVERY > N) begin : g_bad_reg_every
        $error("pipe_shifter: REG_EVERY must be in 1..log2(WIDTH)");
    end

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [N-1:0]     shamt;
        shift_ctl_t       ctl;
        logic [TAG_W-1:0] tag;
    } slot_t;

    slot_t            entry;
    slot_t            slot_p  [NG];
    slot_t            grp_in  [NG];
    slot_t            slot_d  [NG];
    logic [WIDTH-1:0] grp_out [NG];
    logic [NG-1:0]    vld_p;
    logic [NG-1:0]    vld_in;
    logic [NG-1:0]    adv;

    // The SRA fill bit is frozen from the operand MSB here and never recomputed.
    always_comb begin
        entry           = '0;
        entry.data      = in_data;
        entry.shamt     = in_shamt;
        entry.ctl.op    = shift_op_e'(in_op);
        entry.ctl.fill  = in_data[WIDTH-1];
        entry.tag       = in_tag;
    end

    always_comb begin
        for (int k = 0; k < NG; k++) begin
            grp_in[k] = (k == 0) ? entry    : slot_p[(k == 0) ? 0 : k - 1];
            vld_in[k] = (k == 0) ? in_valid : vld_p[(k == 0) ? 0 : k - 1];
        end
    end

    // Ready chain: a slot moves when it is empty or its successor moves.
    always_comb begin
        adv         = '0;
        adv[NG-1]   = !vld_p[NG-1] || out_ready;
        for (int k = NG - 2; k >= 0; k--) begin
            adv[k] = !vld_p[k] || adv[k+1];
        end
    end

    for (genvar g = 0; g < NG; g++) begin : g_group
        localparam int FIRST = g * REG_EVERY;
        localparam int COUNT = (N - FIRST < REG_EVERY) ? (N - FIRST) : REG_EVERY;

        shift_group #(
            .WIDTH (WIDTH),
            .FIRST (FIRST),
            .COUNT (COUNT)
        ) u_group (
            .data   (grp_in[g].data),
            .shamt  (grp_in[g].shamt[FIRST +: COUNT]),
            .op     (grp_in[g].ctl.op),
            .fill   (grp_in[g].ctl.fill),
            .result (grp_out[g])
        );
    end

    always_comb begin
        for (int k = 0; k < NG; k++) begin
            slot_d[k]      = grp_in[k];
            slot_d[k].data = grp_out[k];
        end
    end

    // Slot registers: valid bits reset, payload only loads on a real transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            for (int k = 0; k < NG; k++) begin
                if (adv[k]) vld_p[k] <= vld_in[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NG; k++) begin
            if (adv[k] && vld_in[k]) slot_p[k] <= slot_d[k];
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_p[NG-1];
    assign out_data  = vld_p[NG-1] ? slot_p[NG-1].data : '0;
    assign out_tag   = vld_p[NG-1] ? slot_p[NG-1].tag  : '0;

endmodule
